receptor: RTL and testbench
===========================

RECEPTOR -- requirements
Module: receptor

Interface
REQ-001 SHALL have ports: CLK  input  1  sole clock, rising-edge.
REQ-002 SHALL have ports: CLR  input  1  asynchronous active-high reset.
REQ-003 SHALL have ports: cpu_state  input  3  line state produced by the processor-side MESI FSM.
REQ-004 SHALL have ports: cpu_load  input  1  one-cycle strobe; cpu_state is valid this cycle.
REQ-005 SHALL have ports: bus_valid  input  1  snoop event present on the bus this cycle.
REQ-006 SHALL have ports: bus_event  input  3  one-hot event: [2] invalidate, [1] write miss, [0] read miss.
REQ-007 SHALL have ports: tag_match  input  1  snooped address hits this line.
REQ-008 SHALL have ports: flush_ack  input  1  memory has accepted the write-back data.
REQ-009 SHALL have ports: state  output  3  snoop-side line state.
REQ-010 SHALL have ports: shared  output  1  registered; drives the sh bit of the processor-side CPU event.
REQ-011 SHALL have ports: flush_req  output  1  level request to write the dirty line back.
REQ-012 SHALL have ports: abort_mem  output  1  one-cycle pulse; cache supplies data, memory access aborted.
REQ-013 SHALL have ports: bus_stall  output  1  snoop not accepted; bus holds the event.
REQ-014 SHALL have ports: cpu_retry  output  1  one-cycle pulse; cpu_load was dropped.
REQ-015 SHALL have ports: err  output  1  one-cycle pulse on protocol error or write-back timeout.
REQ-016 SHALL have ports: snoop_hits  output  8  count of accepted snoop hits.

Function
REQ-017 SHALL encode states: I=001, S=010, E=011, M=100, WB_S=101, WB_I=110; codes 000 and 111 are illegal.
REQ-018 SHALL accept a snoop when bus_valid=1, tag_match=1, and state is not WB_S or WB_I.
REQ-019 SHALL treat bus_event values that are not one-hot as a protocol error: err pulses and state is unchanged.
REQ-020 SHALL apply these transitions on an accepted read miss: M->WB_S with flush_req=1 and abort_mem pulse; E->S; S->S; I->I.
REQ-021 SHALL apply these transitions on an accepted write miss: M->WB_I with flush_req=1 and abort_mem pulse; E->I; S->I; I->I.
REQ-022 SHALL apply these transitions on an accepted invalidate: S->I; I->I; E or M->I with an err pulse and no flush.
REQ-023 SHALL set shared=1 in the cycle after an accepted read miss in S, E or M; shared otherwise holds its value and clears on any entry to I.
REQ-024 SHALL hold flush_req=1 in WB_S and WB_I; on flush_ack=1, WB_S->S and WB_I->I next edge and flush_req drops.
REQ-025 SHALL ignore flush_ack outside WB_S and WB_I.
REQ-026 SHALL count write-back cycles with a 4-bit counter; if flush_ack is still absent after 16 cycles, err pulses once, the counter restarts, and flush_req stays high.
REQ-027 SHALL assert bus_stall combinationally when bus_valid=1 and tag_match=1 while in WB_S or WB_I.
REQ-028 SHALL load state from cpu_state on cpu_load=1 when no snoop is accepted that cycle, only if the current state is I, S, E or M and cpu_state is legal.
REQ-029 SHALL resolve a cpu_load that coincides with an accepted snoop in favour of the snoop, drop the load, and pulse cpu_retry.
REQ-030 SHALL resolve a cpu_load in WB_S or WB_I by dropping it and pulsing cpu_retry.
REQ-031 SHALL resolve a cpu_load carrying an illegal cpu_state by dropping it and pulsing err.
REQ-032 SHALL increment snoop_hits by 1 per accepted snoop, wrapping from 255 to 0.
REQ-033 SHALL have a latency of one edge from an accepted event to the new state.
REQ-034 SHALL register all outputs except bus_stall.

Reset
REQ-035 SHALL on CLR, immediately and regardless of CLK, set state=001 (I), shared=0, flush_req=0, abort_mem=0, cpu_retry=0, err=0, snoop_hits=0, and the write-back counter to 0.
REQ-036 SHALL, when CLR is asserted during WB_S or WB_I, abandon the write-back; no flush_req is re-issued after release.

Structure
REQ-037 SHALL place the MESI state codes and the bus_event bit positions in a shared package that is also used by the processor-side FSM.
REQ-038 SHALL implement the write-back timeout as one sub-module, wb_timer, with inputs start, ack and outputs expire.

Verification
REQ-039 SHALL cover: load M, then read-miss hit -> abort_mem pulse, state=101, flush_req=1; flush_ack after 3 cycles -> state=010, shared=1.
REQ-040 SHALL cover: load E, then write-miss hit -> state=001 next edge, no flush_req, snoop_hits=1.
REQ-041 SHALL cover: in WB_I, a snoop hit -> bus_stall=1 and state held; cpu_load in the same cycle -> cpu_retry pulse.
REQ-042 SHALL cover: in WB_S, no flush_ack for 16 cycles -> err pulse on the 16th cycle and flush_req still 1; ack on cycle 20 -> state=010.
REQ-043 SHALL cover: cpu_load=1 with cpu_state=100 simultaneous with a read-miss hit in S -> state=010, cpu_retry pulse; bus_event=011 -> err pulse, state unchanged.
REQ-044 SHALL cover: 256 accepted snoops -> snoop_hits=0; CLR asserted mid-WB_I -> state=001 and flush_req=0 immediately.

Source files
------------

// File: rtl/receptor_pkg.sv
// Shared MESI line-state codes and snoop bus event bit positions, used by both the
// snoop-side receptor and the processor-side FSM.
package receptor_pkg;

  typedef enum logic [2:0] {
    ST_BAD0 = 3'b000,
    ST_I    = 3'b001,
    ST_S    = 3'b010,
    ST_E    = 3'b011,
    ST_M    = 3'b100,
    ST_WB_S = 3'b101,
    ST_WB_I = 3'b110,
    ST_BAD7 = 3'b111
  } mesi_t;

  localparam int EV_RMISS = 0;
  localparam int EV_WMISS = 1;
  localparam int EV_INV   = 2;

  // Last count value of the write-back timer before it reports a timeout.
  localparam logic [3:0] WB_LAST = 4'd15;

  function automatic logic is_one_hot(input logic [2:0] ev);
    return (ev == 3'b001) || (ev == 3'b010) || (ev == 3'b100);
  endfunction

  // The processor side only ever produces the four stable MESI states.
  function automatic logic is_mesi(input logic [2:0] code);
    return (code == ST_I) || (code == ST_S) || (code == ST_E) || (code == ST_M);
  endfunction

endpackage

// File: rtl/receptor_wb_timer.sv
// Write-back timeout: counts cycles while a write-back is pending and flags every
// sixteenth cycle without an acknowledge, restarting the count each time.
module wb_timer
  import receptor_pkg::*;
(
  input  logic CLK,
  input  logic CLR,
  input  logic start,
  input  logic ack,
  output logic expire
);

  logic [3:0] count;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)
      count <= '0;
    else if (!start || ack)
      count <= '0;
    else
      count <= count + 4'd1;
  end

  assign expire = start && !ack && (count == WB_LAST);

endmodule

// File: rtl/receptor.sv
// Snoop-side MESI line controller: reacts to bus snoops, arbitrates against processor
// state loads, and manages the dirty-line write-back handshake.
module receptor
  import receptor_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic [2:0] cpu_state,
  input  logic       cpu_load,
  input  logic       bus_valid,
  input  logic [2:0] bus_event,
  input  logic       tag_match,
  input  logic       flush_ack,
  output logic [2:0] state,
  output logic       shared,
  output logic       flush_req,
  output logic       abort_mem,
  output logic       bus_stall,
  output logic       cpu_retry,
  output logic       err,
  output logic [7:0] snoop_hits
);

  mesi_t st;
  logic  in_wb;
  logic  snoop_hit;
  logic  accept;
  logic  wb_expire;

  assign in_wb     = (st == ST_WB_S) || (st == ST_WB_I);
  assign snoop_hit = bus_valid && tag_match;
  assign accept    = snoop_hit && !in_wb;
  assign bus_stall = snoop_hit && in_wb;
  assign state     = st;

  wb_timer u_wb_timer (
    .CLK   (CLK),
    .CLR   (CLR),
    .start (in_wb),
    .ack   (flush_ack),
    .expire(wb_expire)
  );

  // Priority: accepted snoop, then pending write-back, then processor load.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      st         <= ST_I;
      shared     <= 1'b0;
      flush_req  <= 1'b0;
      abort_mem  <= 1'b0;
      cpu_retry  <= 1'b0;
      err        <= 1'b0;
      snoop_hits <= '0;
    end else begin
      abort_mem <= 1'b0;
      cpu_retry <= 1'b0;
      err       <= 1'b0;
      if (accept) begin
        snoop_hits <= snoop_hits + 8'd1;
        if (cpu_load)
          cpu_retry <= 1'b1;
        if (!is_one_hot(bus_event)) begin
          err <= 1'b1;
        end else if (bus_event[EV_RMISS]) begin
          case (st)
            ST_M: begin
              st        <= ST_WB_S;
              flush_req <= 1'b1;
              abort_mem <= 1'b1;
              shared    <= 1'b1;
            end
            ST_E, ST_S: begin
              st     <= ST_S;
              shared <= 1'b1;
            end
            default: ;
          endcase
        end else if (bus_event[EV_WMISS]) begin
          case (st)
            ST_M: begin
              st        <= ST_WB_I;
              flush_req <= 1'b1;
              abort_mem <= 1'b1;
            end
            ST_E, ST_S: begin
              st     <= ST_I;
              shared <= 1'b0;
            end
            default: ;
          endcase
        end else begin
          // A modified or exclusive line should never see an invalidate; drop it without flushing.
          if ((st == ST_E) || (st == ST_M))
            err <= 1'b1;
          if (st != ST_I) begin
            st     <= ST_I;
            shared <= 1'b0;
          end
        end
      end else if (in_wb) begin
        if (cpu_load)
          cpu_retry <= 1'b1;
        if (flush_ack) begin
          flush_req <= 1'b0;
          if (st == ST_WB_S) begin
            st <= ST_S;
          end else begin
            st     <= ST_I;
            shared <= 1'b0;
          end
        end else if (wb_expire) begin
          err <= 1'b1;
        end
      end else if (cpu_load) begin
        if (is_mesi(cpu_state)) begin
          st <= mesi_t'(cpu_state);
          if (cpu_state == ST_I)
            shared <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_receptor.sv
// Scoreboard bench for receptor: the driver predicts each cycle's outputs from a
// table-driven line model and a separate monitor compares them on the falling edge.
module tb_receptor;

  localparam logic [2:0] I    = 3'b001;
  localparam logic [2:0] S    = 3'b010;
  localparam logic [2:0] E    = 3'b011;
  localparam logic [2:0] M    = 3'b100;
  localparam logic [2:0] WB_S = 3'b101;
  localparam logic [2:0] WB_I = 3'b110;
  localparam logic [2:0] RM   = 3'b001;
  localparam logic [2:0] WM   = 3'b010;
  localparam logic [2:0] INV  = 3'b100;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [2:0] cpu_state;
  logic       cpu_load;
  logic       bus_valid;
  logic [2:0] bus_event;
  logic       tag_match;
  logic       flush_ack;
  logic [2:0] state;
  logic       shared;
  logic       flush_req;
  logic       abort_mem;
  logic       bus_stall;
  logic       cpu_retry;
  logic       err;
  logic [7:0] snoop_hits;

  typedef struct {
    logic [2:0] st;
    logic       sh;
    logic       fr;
    logic       ab;
    logic       stall;
    logic       rt;
    logic       er;
    logic [7:0] hits;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [2:0] m_state;
  logic       m_shared, m_flush, m_abort, m_retry, m_err;
  logic [7:0] m_hits;
  int         m_wb;
  logic [2:0] rm_next [8];
  logic [2:0] wm_next [8];
  logic [2:0] cs_tab [6];

  receptor dut (
    .CLK(CLK), .CLR(CLR), .cpu_state(cpu_state), .cpu_load(cpu_load),
    .bus_valid(bus_valid), .bus_event(bus_event), .tag_match(tag_match),
    .flush_ack(flush_ack), .state(state), .shared(shared), .flush_req(flush_req),
    .abort_mem(abort_mem), .bus_stall(bus_stall), .cpu_retry(cpu_retry),
    .err(err), .snoop_hits(snoop_hits)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_state = I; m_shared = 0; m_flush = 0; m_abort = 0;
    m_retry = 0; m_err = 0; m_hits = 8'd0; m_wb = 0;
  endtask

  // Called at posedge+1: drive one cycle, queue its expected outputs, advance the model.
  task automatic apply_stimulus(input logic v, input logic [2:0] ev, input logic t,
                                input logic ld, input logic [2:0] cs, input logic ack);
    exp_t e;
    logic hit, in_wb;
    bus_valid = v; bus_event = ev; tag_match = t;
    cpu_load = ld; cpu_state = cs; flush_ack = ack;
    in_wb = (m_state == WB_S) || (m_state == WB_I);
    hit = v && t;
    e = '{st: m_state, sh: m_shared, fr: m_flush, ab: m_abort, stall: hit && in_wb,
          rt: m_retry, er: m_err, hits: m_hits};
    sb.push_back(e);
    m_abort = 0; m_retry = 0; m_err = 0;
    if (hit && !in_wb) begin
      m_hits = m_hits + 8'd1;
      if (ld) m_retry = 1;
      if ($countones(ev) != 1) m_err = 1;
      else if (ev == RM) begin
        if (m_state != I) m_shared = 1;
        if (m_state == M) begin m_flush = 1; m_abort = 1; m_wb = 0; end
        m_state = rm_next[m_state];
      end else if (ev == WM) begin
        if (m_state == M) begin m_flush = 1; m_abort = 1; m_wb = 0; end
        else m_shared = 0;
        m_state = wm_next[m_state];
      end else begin
        if (m_state == E || m_state == M) m_err = 1;
        m_state = I; m_shared = 0;
      end
    end else if (in_wb) begin
      if (ld) m_retry = 1;
      if (ack) begin
        if (m_state == WB_I) m_shared = 0;
        m_state = (m_state == WB_S) ? S : I;
        m_flush = 0;
      end else begin
        m_wb++;
        if (m_wb == 16) begin m_err = 1; m_wb = 0; end
      end
    end else if (ld) begin
      if (cs inside {I, S, E, M}) begin
        m_state = cs;
        if (cs == I) m_shared = 0;
      end else m_err = 1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(0, 3'b000, 0, 0, I, 0);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for CLK.
  task automatic pulse_reset();
    bus_valid = 0; cpu_load = 0; flush_ack = 0;
    #2;
    CLR = 1;
    #1;
    check_output("rst_state", {5'd0, state}, {5'd0, I});
    check_output("rst_flush_req", {7'd0, flush_req}, 8'd0);
    check_output("rst_shared", {7'd0, shared}, 8'd0);
    check_output("rst_snoop_hits", snoop_hits, 8'd0);
    model_reset();
    @(posedge CLK);
    #1;
    CLR = 0;
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_output("state", {5'd0, state}, {5'd0, e.st});
      check_output("shared", {7'd0, shared}, {7'd0, e.sh});
      check_output("flush_req", {7'd0, flush_req}, {7'd0, e.fr});
      check_output("abort_mem", {7'd0, abort_mem}, {7'd0, e.ab});
      check_output("bus_stall", {7'd0, bus_stall}, {7'd0, e.stall});
      check_output("cpu_retry", {7'd0, cpu_retry}, {7'd0, e.rt});
      check_output("err", {7'd0, err}, {7'd0, e.er});
      check_output("snoop_hits", snoop_hits, e.hits);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    for (int k = 0; k < 8; k++) begin rm_next[k] = 3'(k); wm_next[k] = 3'(k); end
    rm_next[E] = S; rm_next[M] = WB_S;
    wm_next[S] = I; wm_next[E] = I; wm_next[M] = WB_I;
    cs_tab = '{3'b000, I, S, E, M, 3'b111};

    CLR = 1; cpu_state = I; cpu_load = 0; bus_valid = 0;
    bus_event = 3'b000; tag_match = 0; flush_ack = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    CLR = 0;
    idle(2);

    $display("[TB] dirty line read-missed, acked after three cycles");
    apply_stimulus(0, 3'b000, 0, 1, M, 0);
    apply_stimulus(1, RM, 1, 0, I, 0);
    idle(2);
    apply_stimulus(0, 3'b000, 0, 0, I, 1);
    idle(1);

    $display("[TB] exclusive line write-missed");
    pulse_reset();
    apply_stimulus(0, 3'b000, 0, 1, E, 0);
    apply_stimulus(1, WM, 1, 0, I, 0);
    idle(1);

    $display("[TB] snoop and load during write-back to invalid");
    apply_stimulus(0, 3'b000, 0, 1, M, 0);
    apply_stimulus(1, WM, 1, 0, I, 0);
    apply_stimulus(1, RM, 1, 1, S, 0);
    apply_stimulus(0, 3'b000, 0, 0, I, 1);
    idle(1);

    $display("[TB] write-back timeout with late acknowledge");
    apply_stimulus(0, 3'b000, 0, 1, M, 0);
    apply_stimulus(1, RM, 1, 0, I, 0);
    idle(19);
    apply_stimulus(0, 3'b000, 0, 0, I, 1);
    idle(1);

    $display("[TB] load colliding with snoop, malformed event");
    apply_stimulus(0, 3'b000, 0, 1, S, 0);
    apply_stimulus(1, RM, 1, 1, M, 0);
    apply_stimulus(1, 3'b011, 1, 0, I, 0);
    apply_stimulus(0, 3'b000, 0, 1, 3'b111, 0);
    apply_stimulus(1, INV, 1, 0, I, 0);
    idle(1);

    $display("[TB] snoop counter wrap and reset during write-back");
    pulse_reset();
    for (int k = 0; k < 256; k++) apply_stimulus(1, RM, 1, 0, I, 0);
    idle(1);
    apply_stimulus(0, 3'b000, 0, 1, M, 0);
    apply_stimulus(1, WM, 1, 0, I, 0);
    idle(2);
    pulse_reset();
    idle(3);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 800; k++) begin
      logic [2:0] ev;
      if ($urandom_range(0, 9) < 8) ev = 3'(1 << $urandom_range(0, 2));
      else ev = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) pulse_reset();
      apply_stimulus(1'($urandom_range(0, 1)), ev, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) < 3, cs_tab[$urandom_range(0, 5)],
                     $urandom_range(0, 9) < 2);
    end

    waited = 0;
    while (sb.size() > 0 && waited < 5) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    check_output("scoreboard_drain", 8'(sb.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
